// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, FSM state encodings and flag bundle for the sequential ALU.
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_INC  = 4'b0001;
   localparam logic [3:0] OP_NEGA = 4'b0010;
   localparam logic [3:0] OP_NEGB = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_NOTA = 4'b0111;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SHL  = 4'b1001;
   localparam logic [3:0] OP_SHR  = 4'b1010;
   localparam logic [3:0] OP_SAR  = 4'b1011;
   localparam logic [3:0] OP_MUL  = 4'b1100;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

   typedef struct packed {
      logic z;
      logic c;
      logic s;
      logic v;
   } flags_t;

   // Opcodes above MUL complete with a done pulse but leave results untouched
   function automatic logic op_is_reserved(input logic [3:0] op);
      return (op > OP_MUL);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the control unit (master) and the sequential ALU (slave).
interface alu_seq_if #(parameter int unsigned WIDTH = 8);

   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             cin;
   logic [WIDTH-1:0] R;
   logic [WIDTH-1:0] RH;
   logic             z;
   logic             c;
   logic             s;
   logic             v;
   logic             busy;
   logic             done;

   modport master (
      output start, op, A, B, cin,
      input  R, RH, z, c, s, v, busy, done
   );

   modport slave (
      input  start, op, A, B, cin,
      output R, RH, z, c, s, v, busy, done
   );

endinterface

// File: rtl/alu_core.sv
// Single-cycle combinational datapath: arithmetic, logic and barrel-shift ops 0000-1011.
module alu_core #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] res_c,
   output logic             carry_c,
   output logic             ovf_c
);
   import alu_seq_pkg::*;

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned SW  = WIDTH + 1;

   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             k;
   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   amt;
   logic [WIDTH:0]   shl_ext;
   logic [WIDTH:0]   shr_ext;
   logic [WIDTH:0]   sar_ext;

   // Effective adder operands: every arithmetic op is x + y + k
   always_comb begin
      x = a;
      y = b;
      k = cin;
      unique case (op)
         OP_INC:  y = WIDTH'(1);
         OP_NEGA: begin x = ~a; y = WIDTH'(1); end
         OP_NEGB: begin x = ~b; y = WIDTH'(1); end
         OP_SUB:  begin y = ~b; k = 1'b1; end
         default: ;
      endcase
      sum = {1'b0, x} + {1'b0, y} + SW'(k);
   end

   // Shifts run one bit wider so the last bit shifted out lands in the spare bit
   always_comb begin
      amt     = b[SHW-1:0];
      shl_ext = {1'b0, a} << amt;
      shr_ext = {a, 1'b0} >> amt;
      sar_ext = $signed({a, 1'b0}) >>> amt;
   end

   always_comb begin
      res_c   = '0;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      unique case (op)
         OP_ADD, OP_INC, OP_NEGA, OP_NEGB, OP_SUB: begin
            res_c   = sum[WIDTH-1:0];
            carry_c = sum[WIDTH];
            ovf_c   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
         end
         OP_AND:  res_c = a & b;
         OP_OR:   res_c = a | b;
         OP_XOR:  res_c = a ^ b;
         OP_NOTA: res_c = ~a;
         OP_SHL: begin
            res_c   = shl_ext[WIDTH-1:0];
            carry_c = shl_ext[WIDTH];
         end
         OP_SHR: begin
            res_c   = shr_ext[WIDTH:1];
            carry_c = shr_ext[0];
         end
         OP_SAR: begin
            res_c   = sar_ext[WIDTH:1];
            carry_c = sar_ext[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake and a WIDTH-cycle shift-add multiplier.
module alu_seq #(
   parameter int unsigned WIDTH = 8
) (
   input logic       clk,
   input logic       reset,
   alu_seq_if.slave  bus
);
   import alu_seq_pkg::*;

   localparam int unsigned CNTW = $clog2(WIDTH);

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] rh_q, rh_d;
   flags_t           flags_q, flags_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;

   logic [WIDTH-1:0] core_res_c;
   logic             core_carry_c;
   logic             core_ovf_c;
   logic [WIDTH:0]   step_sum_c;
   logic [WIDTH-1:0] step_hi_c;
   logic [WIDTH-1:0] step_lo_c;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op      (bus.op),
      .a       (bus.A),
      .b       (bus.B),
      .cin     (bus.cin),
      .res_c   (core_res_c),
      .carry_c (core_carry_c),
      .ovf_c   (core_ovf_c)
   );

   // One multiplier step: conditionally add multiplicand to high half, shift {hi,lo} right
   always_comb begin
      step_sum_c = {1'b0, hi_q};
      if (lo_q[0]) begin
         step_sum_c = {1'b0, hi_q} + {1'b0, mcand_q};
      end
      {step_hi_c, step_lo_c} = {step_sum_c, lo_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         r_q     <= '0;
         rh_q    <= '0;
         flags_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         rh_q    <= rh_d;
         flags_q <= flags_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and next-output logic; results hold unless an operation completes
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      rh_d    = rh_q;
      flags_d = flags_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.op == OP_MUL) begin
                  mcand_d = bus.A;
                  lo_d    = bus.B;
                  hi_d    = '0;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = ST_MUL;
               end else begin
                  done_d = 1'b1;
                  if (!op_is_reserved(bus.op)) begin
                     r_d       = core_res_c;
                     rh_d      = '0;
                     flags_d.z = (core_res_c == '0);
                     flags_d.c = core_carry_c;
                     flags_d.s = core_res_c[WIDTH-1];
                     flags_d.v = core_ovf_c;
                  end
               end
            end
         end

         ST_MUL: begin
            hi_d  = step_hi_c;
            lo_d  = step_lo_c;
            cnt_d = cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(WIDTH - 1)) begin
               r_d       = step_lo_c;
               rh_d      = step_hi_c;
               flags_d.z = ({step_hi_c, step_lo_c} == '0);
               flags_d.c = 1'b0;
               flags_d.s = step_hi_c[WIDTH-1];
               flags_d.v = |step_hi_c;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.R    = r_q;
   assign bus.RH   = rh_q;
   assign bus.z    = flags_q.z;
   assign bus.c    = flags_q.c;
   assign bus.s    = flags_q.s;
   assign bus.v    = flags_q.v;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=8 vector table with a done-driven scoreboard, multiplier corner
// sequences, and an exhaustive WIDTH=4 legacy-op sweep against a reference model.
module tb_alu_seq;
   import alu_seq_pkg::*;

   typedef struct {
      string      name;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] r;
      logic [7:0] rh;
      logic       z, c, s, v;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] r;
      logic [7:0] rh;
      logic       z, c, s, v;
   } exp_t;

   localparam int NV = 20;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb_q[$];
   vec_t vecs[NV];

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(8)) bus8 ();
   alu_seq_if #(.WIDTH(4)) bus4 ();

   alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
   alu_seq #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Legacy 4-bit ALU reference: returns {R, z, c, s}
   function automatic logic [6:0] ref4(input int op, input int a, input int b, input int ci);
      int         t;
      logic [3:0] r;
      logic       cy;
      case (op)
         0:       t = a + b + ci;
         1:       t = a + 1 + ci;
         2:       t = (15 - a) + 1 + ci;
         3:       t = (15 - b) + 1 + ci;
         4:       t = a & b;
         5:       t = a | b;
         6:       t = a ^ b;
         default: t = 15 - a;
      endcase
      r  = 4'(t);
      cy = (op < 4) ? t[4] : 1'b0;
      return {r, (r == 4'd0), cy, r[3]};
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding expectation
   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (bus8.done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check(e.name, {bus8.R, bus8.RH, bus8.z, bus8.c, bus8.s, bus8.v},
                  {e.r, e.rh, e.z, e.c, e.s, e.v});
         end
      end
   end

   task automatic drain();
      int t = 0;
      while (sb_q.size() != 0 && t < 40) begin
         @(posedge clk);
         t++;
      end
      #2;
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   task automatic push_exp(input string n, input logic [7:0] r, input logic [7:0] rh,
                           input logic z, input logic c, input logic s, input logic v);
      exp_t e;
      e.name = n; e.r = r; e.rh = rh; e.z = z; e.c = c; e.s = s; e.v = v;
      sb_q.push_back(e);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [6:0] last4;

      //             name         op       a      b      ci    r      rh     z     c     s     v
      vecs[0]  = '{"add_ovf",   OP_ADD,  8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[1]  = '{"sub_zero",  OP_SUB,  8'h05, 8'h05, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{"sub_borrow",OP_SUB,  8'h00, 8'h01, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{"sar3",      OP_SAR,  8'h90, 8'h03, 1'b0, 8'hF2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{"shl1",      OP_SHL,  8'h81, 8'h01, 1'b0, 8'h02, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{"add_cin",   OP_ADD,  8'hFF, 8'h01, 1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{"inc_wrap",  OP_INC,  8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{"nega",      OP_NEGA, 8'h01, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{"negb_zero", OP_NEGB, 8'h33, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{"and",       OP_AND,  8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{"or",        OP_OR,   8'hF0, 8'h0C, 1'b0, 8'hFC, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{"xor_zero",  OP_XOR,  8'hAA, 8'hAA, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{"nota",      OP_NOTA, 8'h0F, 8'h00, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{"shr1",      OP_SHR,  8'h81, 8'h01, 1'b0, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{"shl0",      OP_SHL,  8'h55, 8'h00, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{"sub_ovf",   OP_SUB,  8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[16] = '{"sar7",      OP_SAR,  8'h80, 8'h07, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[17] = '{"reserved",  4'b1110, 8'h12, 8'h34, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[18] = '{"shr_zero",  OP_SHR,  8'h01, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[19] = '{"inc_ovf",   OP_INC,  8'h7F, 8'h00, 1'b1, 8'h81, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};

      bus8.start = 1'b0; bus8.op = '0; bus8.A = '0; bus8.B = '0; bus8.cin = 1'b0;
      bus4.start = 1'b0; bus4.op = '0; bus4.A = '0; bus4.B = '0; bus4.cin = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", 32'({bus8.R, bus8.RH, bus8.z, bus8.c, bus8.s, bus8.v, bus8.busy, bus8.done}), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Back-to-back table: one start per cycle
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         bus8.op = vecs[i].op; bus8.A = vecs[i].a; bus8.B = vecs[i].b; bus8.cin = vecs[i].cin;
         bus8.start = 1'b1;
         push_exp(vecs[i].name, vecs[i].r, vecs[i].rh, vecs[i].z, vecs[i].c, vecs[i].s, vecs[i].v);
      end
      @(negedge clk);
      bus8.start = 1'b0;
      drain();

      // MUL 0xFF*0xFF with ignored ADD starts while busy
      @(negedge clk);
      bus8.op = OP_MUL; bus8.A = 8'hFF; bus8.B = 8'hFF; bus8.start = 1'b1;
      push_exp("mul_ff_ff", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int j = 0; j <= 8; j++) begin
         @(posedge clk);
         #1;
         check($sformatf("mul_busy_%0d", j), 32'(bus8.busy), 32'(j < 8));
         @(negedge clk);
         bus8.start = (j == 1 || j == 4);
         bus8.op = OP_ADD; bus8.A = 8'h01; bus8.B = 8'h01; bus8.cin = 1'b0;
      end
      bus8.start = 1'b0;
      drain();

      // MUL aborted by reset mid-operation
      @(negedge clk);
      bus8.op = OP_MUL; bus8.A = 8'h10; bus8.B = 8'h10; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort_busy_pre", 32'(bus8.busy), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check("abort_outs", 32'({bus8.R, bus8.RH, bus8.z, bus8.c, bus8.s, bus8.v, bus8.busy, bus8.done}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("abort_idle", 32'({bus8.busy, bus8.R, bus8.RH}), 32'd0);
      @(negedge clk);
      bus8.op = OP_ADD; bus8.A = 8'h01; bus8.B = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
      push_exp("add_after_abort", 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      bus8.start = 1'b0;
      drain();

      // WIDTH=4 exhaustive legacy ops
      last4 = '0;
      for (int o = 0; o < 8; o++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               for (int ci = 0; ci < 2; ci++) begin
                  @(negedge clk);
                  bus4.op = 4'(o); bus4.A = 4'(a); bus4.B = 4'(b); bus4.cin = 1'(ci);
                  bus4.start = 1'b1;
                  @(posedge clk);
                  #1;
                  last4 = ref4(o, a, b, ci);
                  check($sformatf("w4_op%0d_a%0h_b%0h_c%0d", o, a, b, ci),
                        32'({bus4.done, bus4.R, bus4.z, bus4.c, bus4.s}), 32'({1'b1, last4}));
               end
            end
         end
      end

      // Reserved op on WIDTH=4: done pulses, outputs held
      @(negedge clk);
      bus4.op = 4'b1110; bus4.A = 4'h3; bus4.B = 4'h5; bus4.cin = 1'b1; bus4.start = 1'b1;
      @(posedge clk);
      #1;
      check("w4_reserved", 32'({bus4.done, bus4.R, bus4.z, bus4.c, bus4.s, bus4.RH, bus4.v}),
            32'({1'b1, last4, 4'h0, 1'b0}));
      @(negedge clk);
      bus4.start = 1'b0;
      @(posedge clk);
      #1;
      check("w4_done_pulse", 32'(bus4.done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
